gpio_port: RTL and testbench

- Memory-mapped GPIO peripheral on the Yduck SoC data bus.
- Drives gpio_out and samples gpio_in, the external pins the SoC testbench stimulates and observes.
- Provides:
  - a 2-flop input synchroniser;
  - an output register with set/clear/toggle aliases;
  - per-bit rising/falling edge capture with a level interrupt to the core.

---
 rtl/gpio_pkg.sv | 19 +
 rtl/gpio_sync.sv | 43 ++++
 rtl/gpio_port.sv | 115 +++++++++++
 tb/tb_gpio_port.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO peripheral.
//   - gpio_addr_t : register word address type (3 bits, 8 word registers)
//   - ADDR_*      : register map constants
package gpio_pkg;

   localparam int GPIO_AW = 3;

   typedef logic [GPIO_AW-1:0] gpio_addr_t;

   localparam gpio_addr_t ADDR_IN      = 3'd0;
   localparam gpio_addr_t ADDR_OUT     = 3'd1;
   localparam gpio_addr_t ADDR_SET     = 3'd2;
   localparam gpio_addr_t ADDR_CLR     = 3'd3;
   localparam gpio_addr_t ADDR_TGL     = 3'd4;
   localparam gpio_addr_t ADDR_RISE_EN = 3'd5;
   localparam gpio_addr_t ADDR_FALL_EN = 3'd6;
   localparam gpio_addr_t ADDR_STAT    = 3'd7;

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: two-flop synchroniser for asynchronous input pins plus one
// extra delay stage, so the edge detector can compare s2 against s3.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-low reset (clears all stages)
//   d    - raw asynchronous pins
//   s2   - synchronised pins (second stage)
//   s3   - s2 delayed by one clock
module gpio_sync #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] s2,
   output logic [DW-1:0] s3
);

   logic [DW-1:0] s1_q, s2_q, s3_q;
   logic [DW-1:0] s1_d, s2_d, s3_d;

   always_comb begin
      s1_d = d;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign s2 = s2_q;
   assign s3 = s3_q;

endmodule

// File: rtl/gpio_port.sv
// gpio_port: memory-mapped GPIO peripheral.
// Output register with SET/CLR/TGL aliases, synchronised input readback,
// per-bit rising/falling edge capture into a write-1-to-clear status
// register, and a level interrupt while any status bit is pending.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous, active-low reset
//   addr     - register word address
//   wdata    - write data
//   we       - write strobe (one cycle per write)
//   re       - read strobe (one cycle per read)
//   rdata    - registered read data, held between reads
//   gpio_in  - external pins, asynchronous to clk
//   gpio_out - output pins (the OUT register itself)
//   irq      - high while any STAT bit is set
module gpio_port
   import gpio_pkg::*;
#(
   parameter int            DW      = 16,
   parameter int            AW      = 3,
   parameter logic [DW-1:0] RST_OUT = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   input  logic          we,
   input  logic          re,
   output logic [DW-1:0] rdata,
   input  logic [DW-1:0] gpio_in,
   output logic [DW-1:0] gpio_out,
   output logic          irq
);

   gpio_addr_t    a;
   logic [DW-1:0] s2, s3;
   logic [DW-1:0] rise, fall, clr;

   logic [DW-1:0] out_q, out_d;
   logic [DW-1:0] rise_en_q, rise_en_d;
   logic [DW-1:0] fall_en_q, fall_en_d;
   logic [DW-1:0] stat_q, stat_d;
   logic [DW-1:0] rdata_q, rdata_d;

   assign a = addr;

   gpio_sync #(.DW(DW)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (gpio_in),
      .s2  (s2),
      .s3  (s3)
   );

   always_comb begin
      out_d     = out_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      rdata_d   = rdata_q;
      clr       = '0;

      if (we) begin
         case (a)
            ADDR_OUT:     out_d     = wdata;
            ADDR_SET:     out_d     = out_q | wdata;
            ADDR_CLR:     out_d     = out_q & ~wdata;
            ADDR_TGL:     out_d     = out_q ^ wdata;
            ADDR_RISE_EN: rise_en_d = wdata;
            ADDR_FALL_EN: fall_en_d = wdata;
            ADDR_STAT:    clr       = wdata;
            default:      ;
         endcase
      end

      // Edge detect on the synchronised pins; a new capture overrides a
      // simultaneous write-1-to-clear of the same bit so no edge is lost.
      rise   = s2 & ~s3;
      fall   = ~s2 & s3;
      stat_d = (stat_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);

      // Reads sample current register values, so a same-cycle write to
      // the addressed register is not yet visible.
      if (re) begin
         case (a)
            ADDR_IN:      rdata_d = s2;
            ADDR_OUT:     rdata_d = out_q;
            ADDR_RISE_EN: rdata_d = rise_en_q;
            ADDR_FALL_EN: rdata_d = fall_en_q;
            ADDR_STAT:    rdata_d = stat_q;
            default:      rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q     <= RST_OUT;
         rise_en_q <= '0;
         fall_en_q <= '0;
         stat_q    <= '0;
         rdata_q   <= '0;
      end else begin
         out_q     <= out_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         stat_q    <= stat_d;
         rdata_q   <= rdata_d;
      end
   end

   assign gpio_out = out_q;
   assign rdata    = rdata_q;
   assign irq      = |stat_q;

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed, table-driven bench for gpio_port, with
// hand-written sequences for synchroniser latency, edge capture,
// clear/set collision, same-address read/write and mid-run reset.
module tb_gpio_port;

   logic        clk;
   logic        rst;
   logic [2:0]  addr;
   logic [15:0] wdata;
   logic        we;
   logic        re;
   logic [15:0] rdata;
   logic [15:0] gpio_in;
   logic [15:0] gpio_out;
   logic        irq;

   int total = 0;
   int bad   = 0;

   gpio_port #(.DW(16), .AW(3), .RST_OUT(16'h0000)) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .wdata    (wdata),
      .we       (we),
      .re       (re),
      .rdata    (rdata),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .irq      (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        we;
      logic        re;
      logic [2:0]  a;
      logic [15:0] wd;
      logic [15:0] exp_rd;
      logic [15:0] exp_out;
   } vec_t;

   vec_t tbl[18];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      we = 1'b1; addr = a; wdata = d;
      tick();
      we = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
      re = 1'b1; addr = a;
      tick();
      re = 1'b0;
      chk(name, rdata, exp);
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; gpio_in = '0;

      tbl[0]  = '{1'b1, 1'b0, 3'd1, 16'h1234, 16'h0000, 16'h1234};
      tbl[1]  = '{1'b1, 1'b0, 3'd2, 16'h000F, 16'h0000, 16'h123F};
      tbl[2]  = '{1'b1, 1'b0, 3'd3, 16'h0204, 16'h0000, 16'h103B};
      tbl[3]  = '{1'b1, 1'b0, 3'd4, 16'hF000, 16'h0000, 16'hE03B};
      tbl[4]  = '{1'b0, 1'b1, 3'd1, 16'h0000, 16'hE03B, 16'hE03B};
      tbl[5]  = '{1'b0, 1'b1, 3'd2, 16'h0000, 16'h0000, 16'hE03B};
      tbl[6]  = '{1'b0, 1'b1, 3'd3, 16'h0000, 16'h0000, 16'hE03B};
      tbl[7]  = '{1'b0, 1'b1, 3'd4, 16'h0000, 16'h0000, 16'hE03B};
      tbl[8]  = '{1'b1, 1'b0, 3'd0, 16'hFFFF, 16'h0000, 16'hE03B};
      tbl[9]  = '{1'b0, 1'b1, 3'd0, 16'h0000, 16'h0000, 16'hE03B};
      tbl[10] = '{1'b1, 1'b0, 3'd5, 16'h00F0, 16'h0000, 16'hE03B};
      tbl[11] = '{1'b0, 1'b1, 3'd5, 16'h0000, 16'h00F0, 16'hE03B};
      tbl[12] = '{1'b1, 1'b0, 3'd6, 16'h0F00, 16'h00F0, 16'hE03B};
      tbl[13] = '{1'b0, 1'b1, 3'd6, 16'h0000, 16'h0F00, 16'hE03B};
      tbl[14] = '{1'b1, 1'b0, 3'd5, 16'h0000, 16'h0F00, 16'hE03B};
      tbl[15] = '{1'b1, 1'b0, 3'd6, 16'h0000, 16'h0F00, 16'hE03B};
      tbl[16] = '{1'b0, 1'b1, 3'd7, 16'h0000, 16'h0000, 16'hE03B};
      tbl[17] = '{1'b0, 1'b1, 3'd1, 16'h0000, 16'hE03B, 16'hE03B};

      // Power-on reset
      #12;
      chk("por_gpio_out", gpio_out, 16'h0000);
      chk("por_irq", {15'b0, irq}, 16'h0000);
      chk("por_rdata", rdata, 16'h0000);
      rst = 1'b1;
      tick();

      // Register map vectors
      for (int i = 0; i < 18; i++) begin
         we = tbl[i].we; re = tbl[i].re; addr = tbl[i].a; wdata = tbl[i].wd;
         tick();
         we = 1'b0; re = 1'b0;
         chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
         chk($sformatf("vec%0d_out", i), gpio_out, tbl[i].exp_out);
         chk($sformatf("vec%0d_irq", i), {15'b0, irq}, 16'h0000);
      end

      // Input synchroniser latency: change sampled at edge k
      gpio_in = 16'hFA1C;
      tick();                                   // edge k
      rd_chk("sync_k1_old", 3'd0, 16'h0000);    // read at edge k+1
      rd_chk("sync_k2_new", 3'd0, 16'hFA1C);    // read at edge k+2
      gpio_in = 16'h0000;
      wait_cycles(4);
      chk("sync_masked_irq", {15'b0, irq}, 16'h0000);

      // Edge capture and interrupt
      wr(3'd5, 16'h0001);
      wr(3'd6, 16'h8000);
      gpio_in = 16'h8001;
      tick();                                   // edge k
      tick();                                   // edge k+1
      chk("cap_irq_early", {15'b0, irq}, 16'h0000);
      tick();                                   // edge k+2
      chk("cap_irq_set", {15'b0, irq}, 16'h0001);
      rd_chk("cap_stat_rise", 3'd7, 16'h0001);
      gpio_in = 16'h0001;
      wait_cycles(3);
      rd_chk("cap_stat_fall", 3'd7, 16'h8001);
      chk("cap_irq_hold", {15'b0, irq}, 16'h0001);
      wr(3'd7, 16'h8001);
      chk("cap_irq_clr", {15'b0, irq}, 16'h0000);
      rd_chk("cap_stat_clr", 3'd7, 16'h0000);

      // Clear/set collision on bit 0
      gpio_in = 16'h0000;
      wait_cycles(4);
      gpio_in = 16'h0001;
      wait_cycles(4);
      chk("col_pre_irq", {15'b0, irq}, 16'h0001);
      gpio_in = 16'h0000;
      wait_cycles(4);
      gpio_in = 16'h0001;
      tick();                                   // edge k
      tick();                                   // edge k+1
      wr(3'd7, 16'h0001);                       // clear lands on edge k+2 with the rise
      chk("col_irq", {15'b0, irq}, 16'h0001);
      rd_chk("col_stat", 3'd7, 16'h0001);
      wr(3'd7, 16'h0001);
      chk("col_irq_after", {15'b0, irq}, 16'h0000);

      // Mask cleared does not drop pending status
      gpio_in = 16'h0000;
      wait_cycles(4);
      gpio_in = 16'h0001;
      wait_cycles(4);
      wr(3'd5, 16'h0000);
      rd_chk("mask_keep_stat", 3'd7, 16'h0001);

      // Same-address read and write
      wr(3'd1, 16'hAAAA);
      we = 1'b1; re = 1'b1; addr = 3'd1; wdata = 16'h5555;
      tick();
      we = 1'b0; re = 1'b0;
      chk("rw_rdata_old", rdata, 16'hAAAA);
      chk("rw_out_new", gpio_out, 16'h5555);
      rd_chk("rw_read_new", 3'd1, 16'h5555);

      // Asynchronous reset mid-run with a read pending
      wr(3'd1, 16'h00FF);
      rd_chk("pre_rst_out", 3'd1, 16'h00FF);
      chk("pre_rst_irq", {15'b0, irq}, 16'h0001);
      re = 1'b1; addr = 3'd1;
      #2;
      rst = 1'b0;
      #1;
      chk("rst_gpio_out", gpio_out, 16'h0000);
      chk("rst_irq", {15'b0, irq}, 16'h0000);
      chk("rst_rdata", rdata, 16'h0000);
      tick();
      chk("rst_rdata_held", rdata, 16'h0000);
      re = 1'b0;
      #2;
      rst = 1'b1;
      tick();
      rd_chk("post_rst_out", 3'd1, 16'h0000);
      rd_chk("post_rst_rise_en", 3'd5, 16'h0000);
      rd_chk("post_rst_stat", 3'd7, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
